// File: rtl/alu_issue_queue.sv
// Operation queue and writeback register in front of the 32-bit combinational ALU.
// Define ALU_ISSUE_BYPASS_EN to let an op arriving at an idle queue skip the FIFO.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_op1,
  input  logic [31:0]              in_op2,
  input  logic [2:0]               in_sel,
  input  logic [RD_W-1:0]          in_rd,
  output logic [31:0]              alu_op1,
  output logic [31:0]              alu_op2,
  output logic [2:0]               alu_sel,
  input  logic [31:0]              alu_result,
  input  logic                     alu_zflag,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [RD_W-1:0]          wb_rd,
  output logic [31:0]              wb_data,
  output logic                     wb_nonzero,
  output logic                     wb_divz,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] SEL_DIV = 3'b100;

  logic [31:0]     op1_q [DEPTH];
  logic [31:0]     op2_q [DEPTH];
  logic [2:0]      sel_q [DEPTH];
  logic [RD_W-1:0] rd_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            wb_nonzero_q, wb_nonzero_d;
  logic            wb_divz_q, wb_divz_d;

  logic head_vld, wb_free, byp, pop, fire, push, divz;

  logic [31:0]     iss_op1, iss_op2;
  logic [2:0]      iss_sel;
  logic [RD_W-1:0] iss_rd;

  assign head_vld = (count_q != '0);
  assign wb_free  = !wb_valid_q || wb_ready;

`ifdef ALU_ISSUE_BYPASS_EN
  assign byp = !head_vld && wb_free && in_valid;
`else
  assign byp = 1'b0;
`endif

  assign pop      = head_vld && wb_free;
  assign fire     = pop || byp;
  // in_ready depends on stored state only so it never combines with wb_ready
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && !byp;

  always_comb begin
    iss_op1 = '0;
    iss_op2 = '0;
    iss_sel = '0;
    iss_rd  = '0;
    if (head_vld) begin
      iss_op1 = op1_q[rd_ptr_q];
      iss_op2 = op2_q[rd_ptr_q];
      iss_sel = sel_q[rd_ptr_q];
      iss_rd  = rd_q[rd_ptr_q];
    end else if (byp) begin
      iss_op1 = in_op1;
      iss_op2 = in_op2;
      iss_sel = in_sel;
      iss_rd  = in_rd;
    end
  end

  assign alu_op1 = iss_op1;
  assign alu_op2 = iss_op2;
  assign alu_sel = iss_sel;

  // The ALU does not detect a zero divisor, so it is caught here on the issue side
  assign divz = (iss_sel == SEL_DIV) && (iss_op2 == '0);

  always_comb begin
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_nonzero_d = wb_nonzero_q;
    wb_divz_d    = wb_divz_q;
    if (fire) begin
      wb_valid_d   = 1'b1;
      wb_rd_d      = iss_rd;
      wb_data_d    = divz ? 32'd0 : alu_result;
      wb_nonzero_d = divz ? 1'b0 : alu_zflag;
      wb_divz_d    = divz;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_nonzero_q <= 1'b0;
      wb_divz_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_nonzero_q <= wb_nonzero_d;
      wb_divz_q    <= wb_divz_d;
    end
  end

  // Queue storage is qualified by count, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      op1_q[wr_ptr_q] <= in_op1;
      op2_q[wr_ptr_q] <= in_op2;
      sel_q[wr_ptr_q] <= in_sel;
      rd_q[wr_ptr_q]  <= in_rd;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_nonzero = wb_nonzero_q;
  assign wb_divz    = wb_divz_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue with a behavioural ALU attached.
module tb_alu_issue_queue;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int LAT  = 1;
  localparam int MAXC = 0;
`else
  localparam int LAT  = 2;
  localparam int MAXC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic [2:0]  in_sel = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_zflag;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_nonzero, wb_divz;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  alu_issue_queue #(.DEPTH(4), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_sel(in_sel), .in_rd(in_rd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zflag(alu_zflag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_nonzero(wb_nonzero), .wb_divz(wb_divz),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: return a * b;
      3'b100: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b101: return a & b;
      3'b110: return a << 1;
      default: return a | b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_op1, alu_op2);
  assign alu_zflag  = (alu_result != 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] s, input logic [4:0] r);
    in_valid = v; in_op1 = a; in_op2 = b; in_sel = s; in_rd = r;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] s, input logic [4:0] r);
    @(negedge clk);
    drive(1'b1, a, b, s, r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(output int lat);
    lat = 1;
    while (!wb_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] d, input logic [4:0] r,
                        input logic nz, input logic dz);
    check({tag, ".valid"}, 32'(wb_valid), 32'd1);
    check({tag, ".data"}, wb_data, d);
    check({tag, ".rd"}, 32'(wb_rd), 32'(r));
    check({tag, ".nonzero"}, 32'(wb_nonzero), 32'(nz));
    check({tag, ".divz"}, 32'(wb_divz), 32'(dz));
  endtask

  initial begin
    int lat;
    int rcv;
    logic cnt_ok;
    logic seen;
    logic [31:0] sd [5];
    logic [4:0]  sr [5];

    repeat (2) @(negedge clk);
    check("rst.count", 32'(count), 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.alu_op1", alu_op1, 32'd0);
    check("rst.alu_sel", 32'(alu_sel), 32'd0);
    rst = 1'b0;

    push_one(32'd7, 32'd5, 3'b000, 5'd3);
    wait_wb(lat);
    check("add.latency", 32'(lat), 32'(LAT));
    chk_wb("add", 32'd12, 5'd3, 1'b1, 1'b0);
    check("add.count", 32'(count), 32'd0);

    push_one(32'd9, 32'd9, 3'b001, 5'd4);
    wait_wb(lat);
    chk_wb("sub", 32'd0, 5'd4, 1'b0, 1'b0);
    push_one(32'd2, 32'd8, 3'b010, 5'd5);
    wait_wb(lat);
    chk_wb("slt", 32'd1, 5'd5, 1'b1, 1'b0);
    push_one(32'hFFFF_FFFF, 32'd1, 3'b010, 5'd6);
    wait_wb(lat);
    chk_wb("slt_neg", 32'd1, 5'd6, 1'b1, 1'b0);
    push_one(32'd100, 32'd0, 3'b100, 5'd7);
    wait_wb(lat);
    chk_wb("div0", 32'd0, 5'd7, 1'b0, 1'b1);
    push_one(32'd100, 32'd7, 3'b100, 5'd8);
    wait_wb(lat);
    chk_wb("div", 32'd14, 5'd8, 1'b1, 1'b0);
    push_one(32'h0001_0001, 32'h0001_0000, 3'b011, 5'd9);
    wait_wb(lat);
    chk_wb("mul", 32'h0001_0000, 5'd9, 1'b1, 1'b0);

    // Stall: five ops with writeback blocked, then a sixth that must be refused
    sd = '{32'd30, 32'h30, 32'h8000_0002, 32'hFF, 32'd42};
    sr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    @(negedge clk);
    wb_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd20, 3'b000, 5'd1);         @(negedge clk);
    drive(1'b1, 32'hF0, 32'h3C, 3'b101, 5'd2);         @(negedge clk);
    drive(1'b1, 32'h4000_0001, 32'd0, 3'b110, 5'd3);   @(negedge clk);
    drive(1'b1, 32'h0F, 32'hF0, 3'b111, 5'd4);         @(negedge clk);
    drive(1'b1, 32'd6, 32'd7, 3'b011, 5'd5);           @(negedge clk);
    drive(1'b1, 32'd1, 32'd1, 3'b000, 5'd6);
    check("full.in_ready", 32'(in_ready), 32'd0);
    check("full.count", 32'(count), 32'd4);
    check("full.wb_valid", 32'(wb_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("full.count_hold", 32'(count), 32'd4);
    check("stall.wb_data", wb_data, sd[0]);
    check("stall.wb_rd", 32'(wb_rd), 32'(sr[0]));
    wb_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d.data", k), wb_data, sd[k]);
      check($sformatf("drain%0d.rd", k), 32'(wb_rd), 32'(sr[k]));
      check($sformatf("drain%0d.count", k), 32'(count), 32'(4 - k));
    end
    @(negedge clk);
    check("drain.wb_valid", 32'(wb_valid), 32'd0);
    check("drain.count", 32'(count), 32'd0);

    // Back-to-back stream with mixed opcodes
    rcv = 0;
    cnt_ok = 1'b1;
    for (int c = 0; c < 16 + LAT; c++) begin
      @(negedge clk);
      if (32'(count) > MAXC) cnt_ok = 1'b0;
      if (wb_valid) begin
        check($sformatf("stream%0d.data", rcv), wb_data,
              alu_f(rcv[2:0], 32'(rcv * 37 + 5), 32'(rcv + 1)));
        check($sformatf("stream%0d.rd", rcv), 32'(wb_rd), 32'(rcv));
        rcv++;
      end
      if (c < 16) drive(1'b1, 32'(c * 37 + 5), 32'(c + 1), c[2:0], c[4:0]);
      else in_valid = 1'b0;
    end
    check("stream.received", 32'(rcv), 32'd16);
    check("stream.count_bound", 32'(cnt_ok), 32'd1);

    // Reset with work queued and a pending writeback
    @(negedge clk);
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(k + 50), 32'd1, 3'b000, 5'(20 + k));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("prerst.count", 32'(count), 32'd3);
    check("prerst.wb_valid", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.count", 32'(count), 32'd0);
    check("midrst.wb_valid", 32'(wb_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.wb_data", wb_data, 32'd0);
    wb_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
    check("midrst.no_stale_wb", 32'(seen), 32'd0);
    push_one(32'd7, 32'd5, 3'b000, 5'd9);
    wait_wb(lat);
    check("postrst.latency", 32'(lat), 32'(LAT));
    chk_wb("postrst", 32'd12, 5'd9, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
